instr_fetch_buffer: RTL and testbench
=====================================

# instr_fetch_buffer

Prefetch unit between the instruction memory and the IF/ID pipeline register of the RV32IM 5-stage core. It replaces the free-running `PC + 4` fetch with a request/response fetch engine that keeps up to `DEPTH` instructions in flight or buffered. It handles multi-cycle instruction memory latency and IF/ID stalls without losing or duplicating instructions. It also flushes cleanly on an EX-stage branch redirect (`pc_src` / `branch_target`).

## Interface
- `DEPTH`, default 4: FIFO entries, power of two, ≥2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `redirect` in 1: EX-stage taken branch/jump (`pc_src`).
- `redirect_pc` in 32: new fetch address (`branch_target`); bits [1:0] are ignored and treated as 00.
- `stall` in 1: IF/ID hold; the head entry is not consumed this cycle.
- `imem_req_valid` out 1: fetch request.
- `imem_req_addr` out 32: word-aligned fetch address.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_resp_valid` in 1: instruction word returned; responses are in order, at least 1 cycle after acceptance.
- `imem_resp_data` in 32: instruction word.
- `if_valid` out 1: head entry is valid.
- `if_pc` out 32: PC of the head entry; 0 when `if_valid`=0.
- `if_instr` out 32: instruction at the head; 32'h0000_0013 (NOP) when `if_valid`=0.

## Operation
- State registers:
  - `fetch_pc`: next request address.
  - `resp_pc`: PC tagged onto the next kept response.
  - `o`: accepted requests not yet answered, including those to be dropped.
  - `d`: responses still to be dropped.
  - FIFO of {pc, instr}.
- Issue rule: `imem_req_valid` = !reset && !redirect && (fifo_count + o < DEPTH). Credits reserve a slot, so the FIFO never overflows.
- Request handshake is per-cycle. `imem_req_valid` may deassert before acceptance (on redirect); the memory tolerates withdrawal.
- On acceptance (valid && ready): `fetch_pc` += 4 and `o`++.
- On response, `o`--, then:
  - if `d`>0: drop the data and `d`--;
  - otherwise: push {`resp_pc`, data} and `resp_pc` += 4.
- Pop: when `if_valid` && !`stall`.
- Redirect has priority over push, pop and issue in the same cycle:
  - FIFO cleared;
  - `fetch_pc` and `resp_pc` set to `redirect_pc`;
  - `d` set to `o` − `imem_resp_valid`; a response arriving in the redirect cycle is dropped;
  - no request is issued that cycle.
- Push and pop may occur in the same cycle; `fifo_count` is unchanged.
- Address arithmetic is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- `o` and `d` widths are $clog2(DEPTH)+1.

## Timing
- Reset values:
  - `if_valid`=0, `if_pc`=0, `if_instr`=NOP;
  - `imem_req_valid`=0 while `reset` is high;
  - `fetch_pc`=`resp_pc`=`RESET_PC`;
  - `o`=`d`=0; FIFO empty.
- First request is issued in the cycle after `reset` deasserts.
- Latency: request accepted at t, response at t+L, `if_valid` with that entry at t+L+1 (macro off).
- Throughput: one instruction per cycle when the memory is pipelined and `DEPTH` ≥ L+1.
- After a redirect in cycle t, the first request to `redirect_pc` goes out at t+1.
- Reset mid-operation discards everything. The instruction memory shares `reset` and returns no responses for pre-reset requests.

## Configuration
- `FETCH_BYPASS_EN` defined: when the FIFO is empty and a kept response arrives, it is presented on `if_*` combinationally in the same cycle. If it is popped (!`stall`), it is not written. Latency becomes t+L.
- `FETCH_BYPASS_EN` undefined: all responses go through the FIFO; outputs come from registers only.
- A bypassed response is never presented during a redirect cycle.

## Structure
- Shared package `fetch_pkg`:
  - `NOP_INSTR` = 32'h0000_0013;
  - default `RESET_PC`;
  - `fetch_entry_t` {pc[31:0], instr[31:0]}.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t` with `push`, `pop`, `flush` (flush highest priority), `count`, `empty`, `full`.
- Top level holds the request/credit/drop logic.

## Test plan
- Reset release, `RESET_PC`=0, memory never responds, ready=1 → requests to 0x0, 0x4, 0x8, 0xC, then `imem_req_valid`=0; `if_valid` stays 0.
- Memory with fixed L=1, `stall`=0 → steady state delivers `if_pc` 0x0, 0x4, 0x8, … one per cycle with the matching `imem_resp_data`.
- `stall` held 10 cycles (L=2) → FIFO reaches 4 entries, requests stop, `if_pc` holds. On release, consecutive PCs with no gap or duplicate.
- Redirect to 0x100 with `o`=3 → the next 3 responses are dropped; the first `if_valid` shows `if_pc`=0x100.
- Redirect in the same cycle as `imem_resp_valid` and a pop → the response is dropped, the FIFO is empty next cycle, and the next request address is `redirect_pc`.
- `reset` asserted with a full FIFO and `o`=2 → next cycle `if_valid`=0, `if_instr`=NOP; the first request after release is to `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and entry type for the instruction prefetch unit
package fetch_pkg;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/instr_fetch_buffer_if.sv
// instr_fetch_buffer_if: request/response channel between fetch engine and instruction memory
interface instr_fetch_buffer_if;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_data;
   modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
   modport slave (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/instr_fetch_buffer_fifo.sv
// fetch_fifo: synchronous FIFO of fetched {pc, instr} entries; flush beats push/pop
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t din,
   output fetch_entry_t head,
   output logic [AW:0]  count,
   output logic         empty,
   output logic         full
);
   localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);
   fetch_entry_t mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   // Status flags and the push/pop actually performed this cycle
   always_comb begin
      empty   = count == '0;
      full    = count == CAP;
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      head    = mem[rd_ptr];
   end
   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
         count  <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
      end
   end
   // Entry storage needs no reset; occupancy decides what is visible
   always_ff @(posedge clk) begin
      if (do_push && !flush && !reset) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: credit-based instruction prefetch with redirect flush (FETCH_BYPASS_EN: same-cycle response bypass)
module instr_fetch_buffer
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   localparam int         CW       = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  redirect,
   input  logic [31:0]           redirect_pc,
   input  logic                  stall,
   instr_fetch_buffer_if.master  imem,
   output logic                  if_valid,
   output logic [31:0]           if_pc,
   output logic [31:0]           if_instr
);
   localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);
   logic [31:0]   fetch_pc, resp_pc;
   logic [CW-1:0] o, d, fifo_count;
   logic          fifo_empty, fifo_full, accept, keep, push, pop, head_valid;
   fetch_entry_t  head, fifo_head;
   // Issue only while an unreserved FIFO slot remains for the answer
   always_comb begin
      imem.req_valid = !reset && !redirect && ({1'b0, fifo_count} + {1'b0, o} < LIMIT);
      imem.req_addr  = fetch_pc;
      accept         = imem.req_valid && imem.req_ready;
      keep           = imem.resp_valid && d == '0 && !redirect && !reset;
   end
`ifdef FETCH_BYPASS_EN
   // A kept response meeting an empty FIFO is shown at once and only stored if not consumed
   always_comb begin
      head_valid = !fifo_empty || keep;
      head       = fifo_empty ? '{pc: resp_pc, instr: imem.resp_data} : fifo_head;
      pop        = !fifo_empty && !stall;
      push       = keep && !fifo_full && !(fifo_empty && !stall);
   end
`else
   // Every kept response is staged in the FIFO; the head comes from storage only
   always_comb begin
      head_valid = !fifo_empty;
      head       = fifo_head;
      pop        = !fifo_empty && !stall;
      push       = keep && !fifo_full;
   end
`endif
   // Present the head, or a harmless NOP bubble when nothing is buffered
   always_comb begin
      if_valid = head_valid;
      if_pc    = head_valid ? head.pc : 32'h0;
      if_instr = head_valid ? head.instr : NOP_INSTR;
   end
   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .din   ('{pc: resp_pc, instr: imem.resp_data}),
      .head  (fifo_head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );
   // Address, in-flight and drop counters; a redirect turns every unanswered request into a drop
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         o        <= '0;
         d        <= '0;
      end else if (redirect) begin
         fetch_pc <= word_align(redirect_pc);
         resp_pc  <= word_align(redirect_pc);
         o        <= o - CW'(imem.resp_valid);
         d        <= o - CW'(imem.resp_valid);
      end else begin
         fetch_pc <= accept ? fetch_pc + 32'd4 : fetch_pc;
         resp_pc  <= keep ? resp_pc + 32'd4 : resp_pc;
         o        <= o + CW'(accept) - CW'(imem.resp_valid);
         d        <= imem.resp_valid && d != '0 ? d - CW'(1) : d;
      end
   end
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: vector table, directed corner cases and random traffic against a stream-level model
module tb_instr_fetch_buffer;
   import fetch_pkg::*;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic redirect = 1'b0;
   logic stall = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic if_valid;
   logic [31:0] if_pc, if_instr;

   always #5 clk = ~clk;

   instr_fetch_buffer_if imem ();

   instr_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .imem        (imem),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_instr    (if_instr)
   );

   int errors = 0;
   int checks = 0;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       q[$];
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] exp_req = 32'h0;
   int          cyc = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   bit          mem_off = 1'b0;
   bit          want_valid = 1'b0;
   bit          got = 1'b0;
   logic [31:0] first_pc = 32'h0;
   int          accepted = 0;
   int          delivered = 0;

   task automatic mem_drive();
      imem.resp_valid = 1'b0;
      imem.resp_data  = 32'h0;
      if (!reset && !mem_off && q.size() > 0 && q[0].due <= cyc) begin
         imem.resp_valid = 1'b1;
         imem.resp_data  = mem_fn(q[0].addr);
         void'(q.pop_front());
      end
   endtask

   task automatic observe();
      int due;
      if (reset) begin
         chk("req_in_reset", 32'(imem.req_valid), 32'h0);
         q.delete();
         exp_pc  = 32'h0;
         exp_req = 32'h0;
         return;
      end
      if (!if_valid) begin
         chk("idle_pc", if_pc, 32'h0);
         chk("idle_instr", if_instr, NOP_INSTR);
      end else if (!redirect) begin
         chk("if_pc", if_pc, exp_pc);
         chk("if_instr", if_instr, mem_fn(exp_pc));
         if (!stall) begin
            exp_pc = exp_pc + 32'd4;
            delivered++;
         end
      end
      if (if_valid && !got) begin
         got = 1'b1;
         first_pc = if_pc;
      end
      if (want_valid) chk("throughput", 32'(if_valid), 32'h1);
      if (redirect) begin
         chk("req_on_redirect", 32'(imem.req_valid), 32'h0);
         exp_pc  = {redirect_pc[31:2], 2'b00};
         exp_req = {redirect_pc[31:2], 2'b00};
      end else if (imem.req_valid) begin
         chk("req_addr", imem.req_addr, exp_req);
         if (imem.req_ready) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (q.size() > 0 && due <= q[$].due) due = q[$].due + 1;
            q.push_back('{imem.req_addr, due});
            exp_req = exp_req + 32'd4;
            accepted++;
         end
      end
      chk("credit_bound", 32'(q.size() <= DEPTH), 32'h1);
   endtask

   task automatic step();
      mem_drive();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      redirect = 1'b0;
      stall = 1'b0;
      mem_off = 1'b0;
      step();
      chk("rst_if_valid", 32'(if_valid), 32'h0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_instr", if_instr, NOP_INSTR);
      chk("rst_req_valid", 32'(imem.req_valid), 32'h0);
      step();
      reset = 1'b0;
      accepted = 0;
      delivered = 0;
      got = 1'b0;
   endtask

   typedef struct {
      logic        ready, resp, stl, redir;
      logic [31:0] raddr, rpc;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        chk_if, exp_if;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vt[12];

   initial begin
      vt[0]  = '{1, 0, 0, 0, 32'h0,   32'h0,   1, 32'h0,   1, 0, 32'h0};
      vt[1]  = '{0, 1, 1, 0, 32'h0,   32'h0,   1, 32'h4,   0, 0, 32'h0};
      vt[2]  = '{1, 0, 1, 0, 32'h0,   32'h0,   1, 32'h4,   1, 1, 32'h0};
      vt[3]  = '{1, 1, 1, 0, 32'h4,   32'h0,   1, 32'h8,   1, 1, 32'h0};
      vt[4]  = '{1, 0, 0, 0, 32'h0,   32'h0,   1, 32'hC,   1, 1, 32'h0};
      vt[5]  = '{1, 1, 0, 0, 32'h8,   32'h0,   1, 32'h10,  1, 1, 32'h4};
      vt[6]  = '{1, 1, 0, 1, 32'hC,   32'h203, 0, 32'h0,   1, 1, 32'h8};
      vt[7]  = '{0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h200, 1, 0, 32'h0};
      vt[8]  = '{1, 1, 0, 0, 32'h10,  32'h0,   1, 32'h200, 1, 0, 32'h0};
      vt[9]  = '{0, 1, 1, 0, 32'h200, 32'h0,   1, 32'h204, 0, 0, 32'h0};
      vt[10] = '{0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h204, 1, 1, 32'h200};
      vt[11] = '{0, 0, 0, 0, 32'h0,   32'h0,   1, 32'h204, 1, 0, 32'h0};

      imem.req_ready = 1'b0;
      imem.resp_valid = 1'b0;
      imem.resp_data = 32'h0;
      @(posedge clk);
      #1;
      do_reset();

      for (int i = 0; i < 12; i++) begin
         imem.req_ready  = vt[i].ready;
         imem.resp_valid = vt[i].resp;
         imem.resp_data  = vt[i].resp ? mem_fn(vt[i].raddr) : 32'h0;
         stall           = vt[i].stl;
         redirect        = vt[i].redir;
         redirect_pc     = vt[i].rpc;
         @(negedge clk);
         chk($sformatf("vec%0d_req_valid", i), 32'(imem.req_valid), 32'(vt[i].exp_req));
         if (vt[i].exp_req) chk($sformatf("vec%0d_req_addr", i), imem.req_addr, vt[i].exp_addr);
         if (vt[i].chk_if) begin
            chk($sformatf("vec%0d_if_valid", i), 32'(if_valid), 32'(vt[i].exp_if));
            chk($sformatf("vec%0d_if_pc", i), if_pc, vt[i].exp_pc);
            chk($sformatf("vec%0d_if_instr", i), if_instr, vt[i].exp_if ? mem_fn(vt[i].exp_pc) : NOP_INSTR);
         end
         @(posedge clk);
         #1;
      end
      redirect = 1'b0;
      stall = 1'b0;

      do_reset();
      mem_off = 1'b1;
      imem.req_ready = 1'b1;
      for (int i = 0; i < 8; i++) step();
      chk("silent_mem_requests", 32'(accepted), 32'd4);
      chk("silent_mem_req_valid", 32'(imem.req_valid), 32'h0);
      chk("silent_mem_if_valid", 32'(if_valid), 32'h0);

      do_reset();
      lat_min = 1;
      lat_max = 1;
      for (int i = 0; i < 16; i++) begin
         want_valid = i >= 6;
         step();
      end
      want_valid = 1'b0;

      do_reset();
      lat_min = 2;
      lat_max = 2;
      stall = 1'b1;
      for (int i = 0; i < 10; i++) step();
      chk("stall_req_stopped", 32'(imem.req_valid), 32'h0);
      chk("stall_if_valid", 32'(if_valid), 32'h1);
      chk("stall_if_pc", if_pc, 32'h0);
      stall = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk("stall_release_progress", 32'(delivered >= 12), 32'h1);

      do_reset();
      lat_min = 6;
      lat_max = 6;
      for (int i = 0; i < 3; i++) step();
      chk("pre_redirect_inflight", 32'(q.size()), 32'd3);
      redirect = 1'b1;
      redirect_pc = 32'h100;
      got = 1'b0;
      step();
      redirect = 1'b0;
      lat_min = 1;
      lat_max = 3;
      for (int i = 0; i < 40 && !got; i++) step();
      chk("redirect_seen", 32'(got), 32'h1);
      chk("redirect_first_pc", first_pc, 32'h100);

      do_reset();
      lat_min = 1;
      lat_max = 1;
      for (int i = 0; i < 8; i++) step();
      redirect = 1'b1;
      redirect_pc = 32'h0000_4A6;
      mem_drive();
      @(negedge clk);
      chk("redir_same_resp", 32'(imem.resp_valid), 32'h1);
      chk("redir_same_pop", 32'(if_valid), 32'h1);
      observe();
      @(posedge clk);
      #1;
      cyc++;
      redirect = 1'b0;
      mem_drive();
      @(negedge clk);
      chk("post_redir_empty", 32'(if_valid), 32'h0);
      chk("post_redir_addr", imem.req_addr, 32'h0000_04A4);
      chk("post_redir_req", 32'(imem.req_valid), 32'h1);
      observe();
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 10; i++) step();

      do_reset();
      lat_min = 3;
      lat_max = 3;
      stall = 1'b1;
      for (int i = 0; i < 6; i++) step();
      do_reset();
      step();
      chk("after_reset_first_req", q.size() > 0 ? q[0].addr : 32'hDEAD_BEEF, 32'h0);

      do_reset();
      lat_min = 1;
      lat_max = 5;
      redirect_pc = 32'h0;
      for (int i = 0; i < 3000; i++) begin
         stall = ($urandom % 4) == 0;
         imem.req_ready = ($urandom % 4) != 0;
         redirect = ($urandom % 25) == 0;
         redirect_pc = ($urandom % 3 == 0) ? 32'hFFFF_FFF0 + ($urandom % 16) : $urandom % 32'h1000;
         if ($urandom % 700 == 0) begin
            redirect = 1'b0;
            reset = 1'b1;
            step();
            reset = 1'b0;
         end else begin
            step();
         end
      end
      chk("random_progress", 32'(delivered > 500), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
